// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder-buffer config: id width, entry types, id helpers
package rob_pkg;
    localparam int ROB_SIZE_WIDTH = 3;
    localparam int ROB_DEPTH      = 1 << ROB_SIZE_WIDTH;

    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

    localparam rob_id_t ROB_ID_NONE  = '0;
    localparam rob_id_t ROB_ID_FIRST = rob_id_t'(1);
    localparam rob_id_t ROB_ID_LAST  = rob_id_t'(ROB_DEPTH - 1);

    typedef enum logic [1:0] {
        ENTRY_REG    = 2'd0,
        ENTRY_STORE  = 2'd1,
        ENTRY_BRANCH = 2'd2
    } entry_type_t;

    // Id 0 means "none", so the ring skips it when wrapping.
    function automatic rob_id_t next_id(input rob_id_t id);
        return (id == ROB_ID_LAST) ? ROB_ID_FIRST : id + rob_id_t'(1);
    endfunction
endpackage

// File: rtl/rob_entry_ram.sv
// rtl/rob_entry_ram.sv - reorder-buffer entry storage: issue write, writeback write, head/ask reads
module rob_entry_ram
    import rob_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        issue_we,
    input  rob_id_t     issue_id,
    input  entry_type_t issue_type,
    input  logic [4:0]  issue_rd,
    input  logic        wb_we,
    input  rob_id_t     wb_id,
    input  logic [31:0] wb_value,
    input  logic        wb_mispredict,
    input  logic [31:0] wb_pc,
    input  logic        retire_we,
    input  rob_id_t     retire_id,
    input  rob_id_t     head_id,
    output logic        head_busy,
    output logic        head_ready,
    output entry_type_t head_type,
    output logic [4:0]  head_rd,
    output logic [31:0] head_value,
    output logic        head_mispredict,
    output logic [31:0] head_pc,
    input  rob_id_t     ask1_id,
    output logic        ask1_busy,
    output logic        ask1_ready,
    output logic [31:0] ask1_value,
    input  rob_id_t     ask2_id,
    output logic        ask2_busy,
    output logic        ask2_ready,
    output logic [31:0] ask2_value
);
    logic [ROB_DEPTH-1:0] busy;
    logic [ROB_DEPTH-1:0] ready;
    logic [ROB_DEPTH-1:0] mispredict;
    entry_type_t          type_q  [ROB_DEPTH];
    logic [4:0]           rd_q    [ROB_DEPTH];
    logic [31:0]          value_q [ROB_DEPTH];
    logic [31:0]          pc_q    [ROB_DEPTH];

    logic wb_hit;
    assign wb_hit = wb_we && busy[wb_id];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            ready      <= '0;
            mispredict <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy  <= '0;
                ready <= '0;
            end else begin
                if (issue_we) begin
                    busy[issue_id]  <= 1'b1;
                    ready[issue_id] <= 1'b0;
                end
                if (wb_hit) begin
                    ready[wb_id]      <= 1'b1;
                    mispredict[wb_id] <= wb_mispredict;
                end
                if (retire_we)
                    busy[retire_id] <= 1'b0;
            end
        end
    end

    // Payload is only ever read behind busy/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rdy && !clear) begin
            if (issue_we) begin
                type_q[issue_id] <= issue_type;
                rd_q[issue_id]   <= issue_rd;
            end
            if (wb_hit) begin
                value_q[wb_id] <= wb_value;
                pc_q[wb_id]    <= wb_pc;
            end
        end
    end

    assign head_busy       = busy[head_id];
    assign head_ready      = ready[head_id];
    assign head_type       = type_q[head_id];
    assign head_rd         = rd_q[head_id];
    assign head_value      = value_q[head_id];
    assign head_mispredict = mispredict[head_id];
    assign head_pc         = pc_q[head_id];
    assign ask1_busy       = busy[ask1_id];
    assign ask1_ready      = ready[ask1_id];
    assign ask1_value      = value_q[ask1_id];
    assign ask2_busy       = busy[ask2_id];
    assign ask2_ready      = ready[ask2_id];
    assign ask2_value      = value_q[ask2_id];
endmodule

// File: rtl/rob.sv
// rtl/rob.sv - reorder buffer top; ROB_BYPASS_EN forwards same-cycle CDB writeback to query and commit
module rob
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [4:0]                issue_rd,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    output logic                      rob_full,
    input  logic                      wb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
    input  logic [31:0]               wb_value,
    input  logic                      wb_mispredict,
    input  logic [31:0]               wb_pc,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
    output logic [31:0]               get_value1,
    output logic [31:0]               get_value2,
    output logic                      get_ready1,
    output logic                      get_ready2,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic                      commit_store,
    output logic                      rob_clear,
    output logic [31:0]               clear_pc
);
    rob_id_t     head, tail, count;
    logic        issue_fire, commit_fire, wb_fire;
    logic        head_busy, head_ready, head_mispredict;
    entry_type_t head_type;
    logic [4:0]  head_rd;
    logic [31:0] head_value, head_pc;
    logic        ask1_busy, ask1_ready, ask2_busy, ask2_ready;
    logic [31:0] ask1_value, ask2_value;
    logic        head_ready_eff, head_mp_eff, ask1_ready_eff, ask2_ready_eff;
    logic [31:0] head_value_eff, head_pc_eff, ask1_value_eff, ask2_value_eff;

    assign rob_full     = (count == ROB_ID_LAST);
    assign issue_fire   = rdy && !rst && issue_valid && !rob_full && !rob_clear;
    assign issue_rob_id = issue_fire ? tail : ROB_ID_NONE;
    assign wb_fire      = wb_valid && (wb_rob_id != ROB_ID_NONE);

`ifdef ROB_BYPASS_EN
    logic wb_head, wb_ask1, wb_ask2;
    assign wb_head        = wb_fire && (wb_rob_id == head);
    assign wb_ask1        = wb_fire && (wb_rob_id == ask_rob_id1);
    assign wb_ask2        = wb_fire && (wb_rob_id == ask_rob_id2);
    assign head_ready_eff = head_ready || wb_head;
    assign head_value_eff = wb_head ? wb_value      : head_value;
    assign head_mp_eff    = wb_head ? wb_mispredict : head_mispredict;
    assign head_pc_eff    = wb_head ? wb_pc         : head_pc;
    assign ask1_ready_eff = ask1_ready || wb_ask1;
    assign ask1_value_eff = wb_ask1 ? wb_value : ask1_value;
    assign ask2_ready_eff = ask2_ready || wb_ask2;
    assign ask2_value_eff = wb_ask2 ? wb_value : ask2_value;
`else
    assign head_ready_eff = head_ready;
    assign head_value_eff = head_value;
    assign head_mp_eff    = head_mispredict;
    assign head_pc_eff    = head_pc;
    assign ask1_ready_eff = ask1_ready;
    assign ask1_value_eff = ask1_value;
    assign ask2_ready_eff = ask2_ready;
    assign ask2_value_eff = ask2_value;
`endif

    // Id 0 is never busy, so it naturally answers not-ready with value 0.
    assign get_ready1 = ask1_busy && ask1_ready_eff;
    assign get_value1 = get_ready1 ? ask1_value_eff : 32'd0;
    assign get_ready2 = ask2_busy && ask2_ready_eff;
    assign get_value2 = get_ready2 ? ask2_value_eff : 32'd0;

    assign commit_fire = !rob_clear && head_busy && head_ready_eff;

    rob_entry_ram u_ram (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clear           (rob_clear),
        .issue_we        (issue_fire),
        .issue_id        (tail),
        .issue_type      (entry_type_t'(issue_type)),
        .issue_rd        (issue_rd),
        .wb_we           (wb_fire),
        .wb_id           (wb_rob_id),
        .wb_value        (wb_value),
        .wb_mispredict   (wb_mispredict),
        .wb_pc           (wb_pc),
        .retire_we       (commit_fire),
        .retire_id       (head),
        .head_id         (head),
        .head_busy       (head_busy),
        .head_ready      (head_ready),
        .head_type       (head_type),
        .head_rd         (head_rd),
        .head_value      (head_value),
        .head_mispredict (head_mispredict),
        .head_pc         (head_pc),
        .ask1_id         (ask_rob_id1),
        .ask1_busy       (ask1_busy),
        .ask1_ready      (ask1_ready),
        .ask1_value      (ask1_value),
        .ask2_id         (ask_rob_id2),
        .ask2_busy       (ask2_busy),
        .ask2_ready      (ask2_ready),
        .ask2_value      (ask2_value)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= ROB_ID_FIRST;
            tail          <= ROB_ID_FIRST;
            count         <= '0;
            commit_rob_id <= ROB_ID_NONE;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_store  <= 1'b0;
            rob_clear     <= 1'b0;
            clear_pc      <= '0;
        end else if (rdy) begin
            commit_rob_id <= ROB_ID_NONE;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_store  <= 1'b0;
            rob_clear     <= 1'b0;
            if (rob_clear) begin
                head  <= ROB_ID_FIRST;
                tail  <= ROB_ID_FIRST;
                count <= '0;
            end else begin
                if (issue_fire)
                    tail <= next_id(tail);
                if (commit_fire) begin
                    head          <= next_id(head);
                    commit_rob_id <= head;
                    commit_store  <= (head_type == ENTRY_STORE);
                    if (head_type == ENTRY_REG) begin
                        commit_rd    <= head_rd;
                        commit_value <= head_value_eff;
                    end
                    // The flush itself lands on the following edge, after this pulse.
                    if (head_type == ENTRY_BRANCH && head_mp_eff) begin
                        rob_clear <= 1'b1;
                        clear_pc  <= head_pc_eff;
                    end
                end
                case ({issue_fire, commit_fire})
                    2'b10:   count <= count + rob_id_t'(1);
                    2'b01:   count <= count - rob_id_t'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - directed self-checking bench for the reorder buffer
module tb_rob;
    localparam logic [1:0] T_REG    = 2'd0;
    localparam logic [1:0] T_STORE  = 2'd1;
    localparam logic [1:0] T_BRANCH = 2'd2;

    logic        clk, rst, rdy;
    logic        issue_valid;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_rob_id;
    logic        rob_full;
    logic        wb_valid;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic        wb_mispredict;
    logic [31:0] wb_pc;
    logic [2:0]  ask_rob_id1, ask_rob_id2;
    logic [31:0] get_value1, get_value2;
    logic        get_ready1, get_ready2;
    logic [2:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        commit_store;
    logic        rob_clear;
    logic [31:0] clear_pc;

    int n_vec = 0;
    int n_bad = 0;

    rob dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_rob_id(issue_rob_id), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_pc(wb_pc),
        .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
        .get_value1(get_value1), .get_value2(get_value2),
        .get_ready1(get_ready1), .get_ready2(get_ready2),
        .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_store(commit_store), .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input int exp_id);
        issue_valid = 1'b1;
        issue_type  = t;
        issue_rd    = rd;
        #1;
        check("issue_id", 32'(issue_rob_id), exp_id);
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wb(input logic [2:0] id, input logic [31:0] v, input logic mp, input logic [31:0] pc);
        wb_valid      = 1'b1;
        wb_rob_id     = id;
        wb_value      = v;
        wb_mispredict = mp;
        wb_pc         = pc;
        step();
        wb_valid      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        issue_valid = 1'b0; issue_type = T_REG; issue_rd = '0;
        wb_valid = 1'b0; wb_rob_id = '0; wb_value = '0; wb_mispredict = 1'b0; wb_pc = '0;
        ask_rob_id1 = '0; ask_rob_id2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_commit_id", 32'(commit_rob_id), 0);
        check("rst_commit_store", 32'(commit_store), 0);
        check("rst_rob_clear", 32'(rob_clear), 0);
        check("rst_rob_full", 32'(rob_full), 0);
        check("rst_clear_pc", clear_pc, 0);
        rst = 1'b0;

        // Single REG issue, writeback, commit.
        issue(T_REG, 5'd5, 1);
        wb(3'd1, 32'h1234, 1'b0, 32'h0);
`ifndef ROB_BYPASS_EN
        check("t1_wait", 32'(commit_rob_id), 0);
        step();
`endif
        check("t1_commit_id", 32'(commit_rob_id), 1);
        check("t1_commit_rd", 32'(commit_rd), 5);
        check("t1_commit_value", commit_value, 32'h1234);
        step();
        check("t1_pulse", 32'(commit_rob_id), 0);

        // Fill to full, refuse, then wrap back to id 1.
        do_reset();
        for (int i = 1; i <= 7; i++)
            issue(T_REG, 5'(i), i);
        check("t2_full", 32'(rob_full), 1);
        issue(T_REG, 5'd8, 0);
        wb(3'd1, 32'hA, 1'b0, 32'h0);
`ifndef ROB_BYPASS_EN
        issue(T_REG, 5'd9, 0);
`endif
        check("t2_commit_id", 32'(commit_rob_id), 1);
        check("t2_not_full", 32'(rob_full), 0);
        issue(T_REG, 5'd10, 1);
        check("t2_full_again", 32'(rob_full), 1);

        // Query ports before and after writeback.
        do_reset();
        issue(T_REG, 5'd1, 1);
        issue(T_REG, 5'd2, 2);
        ask_rob_id1 = 3'd2;
        ask_rob_id2 = 3'd1;
        #1;
        check("t3_pre_ready", 32'(get_ready1), 0);
        check("t3_pre_value", get_value1, 0);
        check("t3_busy_not_ready", 32'(get_ready2), 0);
        wb_valid = 1'b1; wb_rob_id = 3'd2; wb_value = 32'hBEEF; wb_mispredict = 1'b0;
        #1;
`ifdef ROB_BYPASS_EN
        check("t3_same_ready", 32'(get_ready1), 1);
        check("t3_same_value", get_value1, 32'hBEEF);
`else
        check("t3_same_ready", 32'(get_ready1), 0);
        check("t3_same_value", get_value1, 0);
`endif
        step();
        wb_valid = 1'b0;
        #1;
        check("t3_post_ready", 32'(get_ready1), 1);
        check("t3_post_value", get_value1, 32'hBEEF);
        ask_rob_id2 = 3'd0;
        #1;
        check("t3_id0_ready", 32'(get_ready2), 0);
        check("t3_id0_value", get_value2, 0);
        ask_rob_id1 = 3'd0;

        // Mispredicted branch flushes a ready younger entry.
        do_reset();
        issue(T_BRANCH, 5'd0, 1);
        issue(T_REG, 5'd3, 2);
        wb(3'd2, 32'h55, 1'b0, 32'h0);
        wb(3'd1, 32'h0, 1'b1, 32'h100);
`ifndef ROB_BYPASS_EN
        step();
`endif
        check("t4_clear", 32'(rob_clear), 1);
        check("t4_clear_pc", clear_pc, 32'h100);
        check("t4_commit_id", 32'(commit_rob_id), 1);
        check("t4_commit_rd", 32'(commit_rd), 0);
        issue(T_REG, 5'd7, 0);
        check("t4_clear_done", 32'(rob_clear), 0);
        check("t4_no_commit", 32'(commit_rob_id), 0);
        ask_rob_id1 = 3'd2;
        #1;
        check("t4_flushed", 32'(get_ready1), 0);
        ask_rob_id1 = 3'd0;
        step();
        check("t4_no_late_commit", 32'(commit_rob_id), 0);
        issue(T_REG, 5'd8, 1);

        // Out-of-order writeback, in-order commit, STORE pulse, rdy freeze.
        do_reset();
        issue(T_REG, 5'd1, 1);
        issue(T_STORE, 5'd9, 2);
        issue(T_REG, 5'd4, 3);
        wb(3'd3, 32'h33, 1'b0, 32'h0);
        wb(3'd2, 32'h22, 1'b0, 32'h0);
        wb(3'd1, 32'h11, 1'b0, 32'h0);
`ifndef ROB_BYPASS_EN
        check("t5_wait", 32'(commit_rob_id), 0);
        step();
`endif
        check("t5_c1_id", 32'(commit_rob_id), 1);
        check("t5_c1_value", commit_value, 32'h11);
        check("t5_c1_store", 32'(commit_store), 0);
        rdy = 1'b0;
        step();
        check("t5_rdy_hold_id", 32'(commit_rob_id), 1);
        check("t5_rdy_hold_value", commit_value, 32'h11);
        rdy = 1'b1;
        step();
        check("t5_c2_id", 32'(commit_rob_id), 2);
        check("t5_c2_rd", 32'(commit_rd), 0);
        check("t5_c2_value", commit_value, 0);
        check("t5_c2_store", 32'(commit_store), 1);
        step();
        check("t5_c3_id", 32'(commit_rob_id), 3);
        check("t5_c3_rd", 32'(commit_rd), 4);
        check("t5_c3_value", commit_value, 32'h33);
        check("t5_c3_store", 32'(commit_store), 0);
        step();
        check("t5_idle", 32'(commit_rob_id), 0);

        // Asynchronous reset mid-stream.
        do_reset();
        issue(T_REG, 5'd6, 1);
        issue(T_REG, 5'd7, 2);
        issue(T_REG, 5'd8, 3);
        wb(3'd1, 32'h77, 1'b0, 32'h0);
`ifndef ROB_BYPASS_EN
        step();
`endif
        check("t6_commit_before", 32'(commit_rob_id), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_id", 32'(commit_rob_id), 0);
        check("t6_async_rd", 32'(commit_rd), 0);
        check("t6_async_value", commit_value, 0);
        step();
        rst = 1'b0;
        issue(T_REG, 5'd1, 1);
        step();
        check("t6_no_stale_commit", 32'(commit_rob_id), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 ROB_SIZE_WIDTH, from config, default 3; id width; ids 1..2^W-1 usable, id 0 = "none".
REQ-002 clk  in  1  system clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 rdy  in  1  global enable; low freezes all state.
REQ-005 issue_valid  in  1  Decoder requests an entry this cycle.
REQ-006 issue_type  in  2  0=REG, 1=STORE, 2=BRANCH.
REQ-007 issue_rd  in  5  destination register (REG only).
REQ-008 issue_rob_id  out  W  allocated id this cycle, 0 if none.
REQ-009 rob_full  out  1  no free entry; Decoder SHALL NOT issue.
REQ-010 wb_valid / wb_rob_id / wb_value  in  1/W/32  CDB result for an entry.
REQ-011 wb_mispredict / wb_pc  in  1/32  branch result: mispredicted flag, correct pc.
REQ-012 ask_rob_id1, ask_rob_id2  in  W  Reg query ids.
REQ-013 get_value1/2, get_ready1/2  out  32/1  combinational query response.
REQ-014 commit_rob_id / commit_rd / commit_value  out  W/5/32  retirement, id 0 = none.
REQ-015 commit_store  out  1  head STORE retires; LSB may write memory.
REQ-016 rob_clear / clear_pc  out  1/32  pipeline flush and redirect target.

Function
REQ-017 Circular buffer, head/tail pointers over ids 1..2^W-1; successor of 2^W-1 is 1; count register.
REQ-018 issue_rob_id = tail when issue_valid && !rob_full && !rob_clear, else 0; entry (type, rd, ready=0) written that edge, tail advances.
REQ-019 rob_full = (count == 2^W-1) registered-state based; issue while full ignored.
REQ-020 wb_valid with nonzero wb_rob_id sets entry value, ready=1, mispredict flag; writeback to id 0 or empty entry ignored.
REQ-021 Query: get_ready = entry ready && entry busy; get_value = entry value when ready, else 0; id 0 returns ready=0, value=0.
REQ-022 Commit: when head entry busy && ready, retire it combinationally-selected, outputs registered: commit_* valid exactly one cycle after ready is observed, one commit per cycle max.
REQ-023 REG commit: commit_rd=rd, commit_value=value; STORE/BRANCH commit: commit_rd=0, commit_value=0, commit_rob_id=id.
REQ-024 STORE commit additionally pulses commit_store one cycle.
REQ-025 BRANCH commit with mispredict flag: rob_clear=1, clear_pc=wb_pc stored, one cycle; next edge empties buffer (head=tail=1, count=0, all busy=0), commit_* = 0.
REQ-026 Simultaneous issue and commit: count unchanged; issue into full buffer still refused same cycle.
REQ-027 Writeback and commit of same entry same cycle: commit waits one cycle (ready observed from registered state) unless ROB_BYPASS_EN.
REQ-028 Issue during rob_clear cycle refused; issue_rob_id=0.
REQ-029 rdy low: no pointer, entry or output change; outputs hold.

Reset
REQ-030 rst asserts: head=tail=1, count=0, all busy/ready=0, commit_rob_id=0, commit_rd=0, commit_value=0, commit_store=0, rob_clear=0, clear_pc=0; rob_full=0.
REQ-031 Reset mid-operation discards all in-flight entries without committing.

Configuration
REQ-032 ROB_BYPASS_EN defined: same-cycle CDB writeback forwarded to query ports (ask id == wb_rob_id gives get_ready=1, get_value=wb_value) and to head commit check.
REQ-033 ROB_BYPASS_EN undefined: query and commit see only registered entry state; one extra cycle latency.

Structure
REQ-034 Shared config package/header holds ROB_SIZE_WIDTH, entry-type encodings, id-0 "none" constant.
REQ-035 One sub-module rob_entry_ram: entry storage with one write-issue port, one writeback port, three read ports (head, ask1, ask2).

Verification
REQ-036 Issue REG rd=5 -> id 1; wb id1 value 0x1234 -> next cycle commit_rob_id=1, commit_rd=5, commit_value=0x1234.
REQ-037 Fill 7 entries (W=3) -> rob_full=1, 8th issue yields issue_rob_id=0; commit id1 then issue -> id 1 reused (wrap).
REQ-038 ask_rob_id1=2 before wb -> ready=0, value 0; wb id2 0xBEEF -> ready=1, value 0xBEEF (same cycle only with ROB_BYPASS_EN).
REQ-039 BRANCH id1 mispredict wb_pc=0x100, REG id2 ready -> rob_clear=1, clear_pc=0x100, id2 never commits, count=0.
REQ-040 Out-of-order wb id3 then id2 then id1 -> commits strictly 1,2,3 on consecutive cycles; STORE id pulses commit_store, commit_rd=0.
REQ-041 rst asserted asynchronously mid-stream -> all outputs 0 immediately, next issue returns id 1.
